// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory controller: FSM encoding, default widths
// and the byte-lane helper used to size write-enable buses.
package dmem_pkg;

    localparam int DEF_DATA_WIDTH  = 24;
    localparam int DEF_ADDR_WIDTH  = 8;
    localparam int DEF_DEPTH       = 256;
    localparam int DEF_WAIT_STATES = 1;
    localparam int BYTE_WIDTH      = 8;

    typedef logic [1:0] state_t;

    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_WAIT   = 2'd1;
    localparam state_t S_ACCESS = 2'd2;
    localparam state_t S_RESP   = 2'd3;

    function automatic int lane_count(input int data_width);
        return data_width / BYTE_WIDTH;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x DATA_WIDTH storage, one independent byte-wide array per lane so each lane
// maps onto its own block RAM with a registered read port. No reset on contents.
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DEPTH      = DEF_DEPTH
) (
    input  logic                                clk,
    input  logic                                we,
    input  logic                                re,
    input  logic [ADDR_WIDTH-1:0]               addr,
    input  logic [DATA_WIDTH-1:0]               wdata,
    input  logic [lane_count(DATA_WIDTH)-1:0]   be,
    output logic [DATA_WIDTH-1:0]               rdata
);

    localparam int LANES = lane_count(DATA_WIDTH);

    for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
        logic [BYTE_WIDTH-1:0] mem [DEPTH];
        logic [BYTE_WIDTH-1:0] rd_reg;

        always_ff @(posedge clk) begin
            if (we && be[gi]) begin
                mem[addr] <= wdata[gi*BYTE_WIDTH +: BYTE_WIDTH];
            end
            if (re) begin
                rd_reg <= mem[addr];
            end
        end

        assign rdata[gi*BYTE_WIDTH +: BYTE_WIDTH] = rd_reg;
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Stallable data-memory controller: valid/ready request, programmable wait states,
// byte-lane writes, registered response. Define DMEM_BOUNDS_CHECK_EN to drive rsp_err.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int DATA_WIDTH  = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH  = DEF_ADDR_WIDTH,
    parameter int DEPTH       = DEF_DEPTH,
    parameter int WAIT_STATES = DEF_WAIT_STATES
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic                                req_we,
    input  logic [ADDR_WIDTH-1:0]               req_addr,
    input  logic [DATA_WIDTH-1:0]               req_wdata,
    input  logic [lane_count(DATA_WIDTH)-1:0]   req_be,
    output logic                                rsp_valid,
    output logic [DATA_WIDTH-1:0]               rsp_rdata,
    output logic                                rsp_err
);

    localparam int         LANES     = lane_count(DATA_WIDTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);
    localparam state_t     ACCEPT_TO = (WAIT_STATES == 0) ? S_ACCESS : S_WAIT;

    state_t                  state_reg;
    logic [3:0]              cnt_reg;
    logic                    we_reg;
    logic [ADDR_WIDTH-1:0]   addr_reg;
    logic [DATA_WIDTH-1:0]   wdata_reg;
    logic [LANES-1:0]        be_reg;
    logic                    oor_reg;
    logic                    rsp_valid_reg;
    logic [DATA_WIDTH-1:0]   rsp_rdata_reg;
    logic [DATA_WIDTH-1:0]   arr_rdata;
    logic                    arr_we;
    logic                    arr_re;

    // Out-of-range requests never touch the array; the read path substitutes zero.
    assign arr_we = (state_reg == S_ACCESS) && we_reg && !oor_reg;
    assign arr_re = (state_reg == S_ACCESS) && !we_reg && !oor_reg;

    dmem_array #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH),
        .DEPTH      (DEPTH)
    ) u_array (
        .clk   (clk),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (addr_reg),
        .wdata (wdata_reg),
        .be    (be_reg),
        .rdata (arr_rdata)
    );

    assign req_ready = rst_n && ((state_reg == S_IDLE) || (state_reg == S_RESP));

    // The array's registered read lands during RESP; the response registers capture
    // it on the RESP exit edge, so rsp_valid rises WAIT_STATES+2 edges after accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            cnt_reg       <= 4'd0;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            be_reg        <= '0;
            oor_reg       <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= '0;
        end else begin
            rsp_valid_reg <= (state_reg == S_RESP);
            if ((state_reg == S_RESP) && !we_reg) begin
                rsp_rdata_reg <= oor_reg ? '0 : arr_rdata;
            end
            case (state_reg)
                S_IDLE, S_RESP: begin
                    if (req_valid) begin
                        we_reg    <= req_we;
                        addr_reg  <= req_addr;
                        wdata_reg <= req_wdata;
                        be_reg    <= req_be;
                        oor_reg   <= (int'(req_addr) >= DEPTH);
                        cnt_reg   <= WAIT_INIT;
                        state_reg <= ACCEPT_TO;
                    end else begin
                        state_reg <= S_IDLE;
                    end
                end
                S_WAIT: begin
                    if (cnt_reg == 4'd0) begin
                        state_reg <= S_ACCESS;
                    end else begin
                        cnt_reg <= cnt_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= S_RESP;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;

`ifdef DMEM_BOUNDS_CHECK_EN
    logic rsp_err_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err_reg <= 1'b0;
        end else begin
            rsp_err_reg <= (state_reg == S_RESP) && oor_reg;
        end
    end

    assign rsp_err = rsp_err_reg;
`else
    assign rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: dut0 uses defaults (WAIT_STATES=1, DEPTH=256),
// dut1 uses WAIT_STATES=0, DEPTH=200 for latency and out-of-range cases.
module tb_dmem_ctrl;

`ifdef DMEM_BOUNDS_CHECK_EN
    localparam logic BC = 1'b1;
`else
    localparam logic BC = 1'b0;
`endif

    typedef struct {
        logic [23:0] rdata;
        logic        err;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst0_n, rst1_n;
    logic        v0, we0, v1, we1;
    logic [7:0]  addr0, addr1;
    logic [23:0] wdata0, wdata1;
    logic [2:0]  be0, be1;
    logic        ready0, rv0, err0, ready1, rv1, err1;
    logic [23:0] rd0, rd1;

    exp_t        q0[$];
    exp_t        q1[$];
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          w;
    logic [23:0] last0, last1;

    dmem_ctrl #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .DEPTH(256), .WAIT_STATES(1)) dut0 (
        .clk(clk), .rst_n(rst0_n), .req_valid(v0), .req_ready(ready0), .req_we(we0),
        .req_addr(addr0), .req_wdata(wdata0), .req_be(be0),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(err0)
    );

    dmem_ctrl #(.DATA_WIDTH(24), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(0)) dut1 (
        .clk(clk), .rst_n(rst1_n), .req_valid(v1), .req_ready(ready1), .req_we(we1),
        .req_addr(addr1), .req_wdata(wdata1), .req_be(be1),
        .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(err1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitors: pop one expectation per response strobe.
    always @(negedge clk) begin : mon0
        exp_t e;
        if (rv0 === 1'b1) begin
            if (q0.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut0_unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                e = q0.pop_front();
                check("dut0_rdata", 32'(rd0), 32'(e.rdata));
                check("dut0_err", 32'(err0), 32'(e.err));
                check("dut0_latency", 32'(cyc - e.cyc - 1), 32'd3);
                $display("dut0 rsp rdata=0x%06h err=%0b", rd0, err0);
            end
        end
    end

    always @(negedge clk) begin : mon1
        exp_t e;
        if (rv1 === 1'b1) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_rsp: got rsp_valid=1 expected no response");
            end else begin
                e = q1.pop_front();
                check("dut1_rdata", 32'(rd1), 32'(e.rdata));
                check("dut1_err", 32'(err1), 32'(e.err));
                check("dut1_latency", 32'(cyc - e.cyc - 1), 32'd2);
                $display("dut1 rsp rdata=0x%06h err=%0b", rd1, err1);
            end
        end
    end

    // Drive a request and hold it until accepted; waits = not-ready negedges seen.
    task automatic issue(input int d, input logic we, input logic [7:0] addr,
                         input logic [23:0] wdata, input logic [2:0] be,
                         input logic [23:0] exp_rd, input logic exp_err, output int waits);
        exp_t e;
        logic rdy;
        waits = 0;
        rdy = 1'b0;
        @(negedge clk);
        if (d == 0) begin
            v0 = 1'b1; we0 = we; addr0 = addr; wdata0 = wdata; be0 = be;
        end else begin
            v1 = 1'b1; we1 = we; addr1 = addr; wdata1 = wdata; be1 = be;
        end
        for (int i = 0; i < 50; i++) begin
            rdy = (d == 0) ? ready0 : ready1;
            if (rdy) break;
            waits++;
            @(negedge clk);
        end
        if (!rdy) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_accept_timeout: got req_ready=0 expected 1", d);
        end else begin
            if (we) begin
                e.rdata = (d == 0) ? last0 : last1;
            end else begin
                e.rdata = exp_rd;
                if (d == 0) last0 = exp_rd; else last1 = exp_rd;
            end
            e.err = exp_err;
            e.cyc = cyc;
            if (d == 0) q0.push_back(e); else q1.push_back(e);
            $display("dut%0d req we=%0b addr=%0d wdata=0x%06h be=%03b", d, we, addr, wdata, be);
            @(posedge clk);
        end
    endtask

    task automatic idle(input int d);
        @(negedge clk);
        if (d == 0) v0 = 1'b0; else v1 = 1'b0;
    endtask

    task automatic drain();
        for (int i = 0; i < 30 && (q0.size() != 0 || q1.size() != 0); i++) @(negedge clk);
        @(negedge clk);
        check("drain_q0", 32'(q0.size()), 32'd0);
        check("drain_q1", 32'(q1.size()), 32'd0);
    endtask

    initial begin
        rst0_n = 1'b0; rst1_n = 1'b0;
        v0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0; be0 = '0;
        v1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0; be1 = '0;
        last0 = '0; last1 = '0;
        repeat (2) @(negedge clk);
        check("rst_ready0", 32'(ready0), 32'd0);
        check("rst_valid0", 32'(rv0), 32'd0);
        check("rst_rdata0", 32'(rd0), 32'd0);
        check("rst_err0", 32'(err0), 32'd0);
        check("rst_ready1", 32'(ready1), 32'd0);
        check("rst_valid1", 32'(rv1), 32'd0);
        @(negedge clk);
        rst0_n = 1'b1; rst1_n = 1'b1;

        // Basic write/read, preload, then back-to-back reads with valid held high.
        issue(0, 1'b1, 8'd16, 24'h00000A, 3'b111, 24'h0, 1'b0, w);
        issue(0, 1'b0, 8'd16, 24'h0, 3'b000, 24'h00000A, 1'b0, w);
        issue(0, 1'b1, 8'd32, 24'h000017, 3'b111, 24'h0, 1'b0, w);
        issue(0, 1'b0, 8'd16, 24'h0, 3'b101, 24'h00000A, 1'b0, w);
        issue(0, 1'b0, 8'd32, 24'h0, 3'b000, 24'h000017, 1'b0, w);
        check("b2b_not_ready_cycles", 32'(w), 32'd2);

        // Byte lanes and the be=0 no-op write.
        issue(0, 1'b1, 8'd16, 24'hABCDEF, 3'b010, 24'h0, 1'b0, w);
        issue(0, 1'b0, 8'd16, 24'h0, 3'b000, 24'h00CD0A, 1'b0, w);
        issue(0, 1'b1, 8'd16, 24'hFFFFFF, 3'b000, 24'h0, 1'b0, w);
        issue(0, 1'b0, 8'd16, 24'h0, 3'b000, 24'h00CD0A, 1'b0, w);
        idle(0);
        drain();

        // Reset while the write sits in WAIT: no response, no array update.
        issue(0, 1'b1, 8'd32, 24'h123456, 3'b111, 24'h0, 1'b0, w);
        @(negedge clk);
        rst0_n = 1'b0;
        v0 = 1'b0;
        #1;
        check("midrst_ready", 32'(ready0), 32'd0);
        check("midrst_valid", 32'(rv0), 32'd0);
        check("midrst_rdata", 32'(rd0), 32'd0);
        check("midrst_err", 32'(err0), 32'd0);
        q0.delete();
        last0 = '0;
        repeat (2) @(negedge clk);
        rst0_n = 1'b1;
        repeat (5) @(negedge clk);
        issue(0, 1'b0, 8'd32, 24'h0, 3'b000, 24'h000017, 1'b0, w);
        idle(0);

        // Zero wait states, out-of-range access, read data held across writes.
        issue(1, 1'b1, 8'd5, 24'h111111, 3'b111, 24'h0, 1'b0, w);
        issue(1, 1'b0, 8'd5, 24'h0, 3'b000, 24'h111111, 1'b0, w);
        issue(1, 1'b1, 8'd250, 24'h222222, 3'b111, 24'h0, BC, w);
        issue(1, 1'b0, 8'd250, 24'h0, 3'b000, 24'h000000, BC, w);
        issue(1, 1'b0, 8'd5, 24'h0, 3'b000, 24'h111111, 1'b0, w);
        issue(1, 1'b1, 8'd6, 24'h333333, 3'b111, 24'h0, 1'b0, w);
        idle(1);
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
